spawn_dispatcher: RTL and testbench
===================================

Name: spawn_dispatcher

Overview:
- Sits directly downstream of the processor array and consumes each processor's SPAWN requests (TRIGGER_SPAWN toggle + SPAWN_ADDR).
- Buffers requests in a small address FIFO and starts idle processors at the queued addresses by driving their START/START_ADDR.
- Boots the cluster by starting processor 0 at BOOT_ADDR after reset.
- Reports ALL_IDLE when no work remains anywhere.

Parameters:
- N_PROC, 4, number of attached processors (2..8).
- FIFO_DEPTH, 8, spawn-address FIFO entries (power of two, 2..16).
- BOOT_ADDR, 8'h00, code address started on processor 0 after reset.

Ports:
- clock  in  1  system clock (processors share it).
- reset  in  1  synchronous, active-high reset.
- RUN  in  N_PROC  RUN output of each processor.
- TRIGGER_SPAWN  in  N_PROC  per-processor request toggle.
- SPAWN_ADDR  in  8*N_PROC  per-processor spawn address; slice i = [8i+7:8i].
- DISP_ACK  out  N_PROC  per-processor acknowledge toggle.
- START  out  N_PROC  one-cycle start pulse per processor.
- START_ADDR  out  8*N_PROC  start address per processor; slice as SPAWN_ADDR.
- ALL_IDLE  out  1  cluster finished.
- FIFO_COUNT  out  5  current FIFO occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - DISP_ACK=0, START=0, START_ADDR=0, FIFO empty, FIFO_COUNT=0, ALL_IDLE=0, state=BOOT.
  - seen[i] <= TRIGGER_SPAWN[i], so stale toggles are not taken as requests.
  - Reset asserted mid-operation discards all queued addresses. Processors already running are not stopped.
- Request detect: pending[i] = TRIGGER_SPAWN[i] != seen[i].
- Intake, once per cycle, only when FIFO_COUNT < FIFO_DEPTH:
  - Round-robin pick one pending processor, starting from the index after the last granted one (initial pointer 0).
  - Push SPAWN_ADDR slice, set seen[i] <= TRIGGER_SPAWN[i], toggle DISP_ACK[i] on the same edge.
  - The processor sees the ack the next cycle.
- FIFO full: no pick, no ack. Requesters stall in SPAWN until space frees.
- Dispatch: idle[i] = ~RUN[i] & ~START[i].
  - START is included in the idle term because RUN rises only one cycle after START.
  - If FIFO non-empty and any idle processor exists, pop head, drive START[lowest idle i]=1 and START_ADDR slice i=head for exactly one cycle.
  - Push-to-START latency is 1 cycle minimum: an address pushed at edge t is poppable at edge t+1.
  - The FIFO does not bypass from intake to dispatch.
- Simultaneous push and pop in one cycle: both performed, count unchanged.
  - The full check uses the pre-pop count, so a full FIFO with a pop in the same cycle still refuses the push.
- Per-processor slots: START_ADDR slices hold their last value; only the START bit is cleared.
- FIFO pointers wrap modulo FIFO_DEPTH.
- State machine:
  - BOOT: START[0]=1, START_ADDR[0]=BOOT_ADDR for one cycle -> RUNNING. Intake is active in BOOT; dispatch is not.
  - RUNNING: intake + dispatch as above.
  - RUNNING -> DONE when all of: FIFO empty, no pending, RUN==0, START==0, for 2 consecutive cycles. This covers a HLT racing a final spawn.
  - DONE: ALL_IDLE=1.
  - DONE -> RUNNING, with ALL_IDLE=0, on any pending request. Only reset re-enters BOOT.
- A processor that spawns and halts in the same cycle is handled normally; its own slot becomes eligible for dispatch.

Optional Feature:
- Macro DISPATCH_STATS_EN.
- Defined: adds outputs
  - SPAWN_TOTAL (16): saturating count of pushes.
  - START_TOTAL (16): saturating count of START pulses, boot included.
  - FIFO_HWM (5): maximum FIFO_COUNT seen.
  - All three clear on reset.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- Boot: reset 2 cycles, release, all RUN=0 -> START=4'b0001, START_ADDR[0]=8'h00 in the first cycle after reset; no other START.
- Single spawn: P0 running, toggles TRIGGER_SPAWN[0] with SPAWN_ADDR=8'h20 -> DISP_ACK[0] toggles next edge; the following cycle START[1]=1 with START_ADDR[1]=8'h20 (P1 lowest idle).
- Round-robin: P0..P3 toggle in the same cycle with addresses 8'h10..8'h13 -> acks on 4 consecutive edges in order 0,1,2,3; FIFO_COUNT peaks at 1 or 2 depending on dispatch; starts follow in FIFO order.
- Backpressure: FIFO_DEPTH=2, all RUN=1, three requests -> two acks, third DISP_ACK holds; after one processor drops RUN, a pop occurs, then the third ack fires.
- Completion: all processors halt, FIFO empty -> ALL_IDLE=1 exactly 2 cycles after the last RUN fall; a new toggle clears it.
- Reset mid-run: FIFO_COUNT=3, assert reset -> FIFO_COUNT=0, DISP_ACK=0, no START until the BOOT pulse; a TRIGGER_SPAWN level held through reset is not acked.

Source files
------------

// File: rtl/spawn_dispatcher_if.sv
// Bundle of the processor-array signals seen by the spawn dispatcher.
// master: dispatcher side (drives acks, starts, status); slave: processor-array side.
// Ports: RUN/TRIGGER_SPAWN/SPAWN_ADDR from processors; DISP_ACK/START/START_ADDR/ALL_IDLE/FIFO_COUNT back.
// Macro DISPATCH_STATS_EN adds SPAWN_TOTAL, START_TOTAL and FIFO_HWM.
interface spawn_dispatcher_if #(
    parameter int N_PROC = 4
);
    logic [N_PROC-1:0]   RUN;
    logic [N_PROC-1:0]   TRIGGER_SPAWN;
    logic [8*N_PROC-1:0] SPAWN_ADDR;
    logic [N_PROC-1:0]   DISP_ACK;
    logic [N_PROC-1:0]   START;
    logic [8*N_PROC-1:0] START_ADDR;
    logic                ALL_IDLE;
    logic [4:0]          FIFO_COUNT;
`ifdef DISPATCH_STATS_EN
    logic [15:0]         SPAWN_TOTAL;
    logic [15:0]         START_TOTAL;
    logic [4:0]          FIFO_HWM;
`endif

    modport master (
        input  RUN, TRIGGER_SPAWN, SPAWN_ADDR,
`ifdef DISPATCH_STATS_EN
        output SPAWN_TOTAL, START_TOTAL, FIFO_HWM,
`endif
        output DISP_ACK, START, START_ADDR, ALL_IDLE, FIFO_COUNT
    );

    modport slave (
        output RUN, TRIGGER_SPAWN, SPAWN_ADDR,
`ifdef DISPATCH_STATS_EN
        input  SPAWN_TOTAL, START_TOTAL, FIFO_HWM,
`endif
        input  DISP_ACK, START, START_ADDR, ALL_IDLE, FIFO_COUNT
    );
endinterface

// File: rtl/spawn_dispatcher.sv
// Collects processor SPAWN requests into an address FIFO and starts idle processors at queued addresses.
// Latency: request ack on the next edge; START at the earliest one edge after the push (no bypass).
// Backpressure: a full FIFO withholds acks, so requesters stall until a pop frees a slot.
// Ports: clock, reset (sync, active-high), bus (spawn_dispatcher_if.master).
// Optional: DISPATCH_STATS_EN adds SPAWN_TOTAL, START_TOTAL, FIFO_HWM counters.
module spawn_dispatcher #(
    parameter int         N_PROC     = 4,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] BOOT_ADDR  = 8'h00
) (
    input  logic                 clock,
    input  logic                 reset,
    spawn_dispatcher_if.master   bus
);

    localparam int PW = (N_PROC > 1) ? $clog2(N_PROC) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUNNING,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [N_PROC-1:0]   seen_q;
    logic [N_PROC-1:0]   ack_q;
    logic [N_PROC-1:0]   start_q, start_d;
    logic [8*N_PROC-1:0] start_addr_q;
    logic [4:0]          count_q;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]       rr_ptr_q;
    logic                quiet_q;
    logic [7:0]          mem [FIFO_DEPTH];

    logic [N_PROC-1:0]   pending;
    logic [N_PROC-1:0]   idle;
    logic                pick_vld;
    logic [PW-1:0]       pick_idx;
    logic                disp_vld;
    logic [PW-1:0]       disp_idx;
    logic                push;
    logic                pop;
    logic                quiet;

    assign pending = bus.TRIGGER_SPAWN ^ seen_q;
    // START counts as busy: RUN only rises the cycle after the pulse.
    assign idle    = ~bus.RUN & ~start_q;
    assign quiet   = (count_q == 5'd0) && (pending == '0) && (bus.RUN == '0) && (start_q == '0);

    // Round-robin search starting just past the last granted requester.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = 0; k < N_PROC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_PROC) idx = idx - N_PROC;
            if (!pick_vld && pending[idx]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(idx);
            end
        end
    end

    // Lowest-numbered idle processor wins.
    always_comb begin
        disp_vld = 1'b0;
        disp_idx = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (idle[i]) begin
                disp_vld = 1'b1;
                disp_idx = PW'(i);
            end
        end
    end

    // Full test uses the pre-pop count: a pop never makes room for a push in the same cycle.
    assign push = pick_vld && (count_q < 5'(FIFO_DEPTH));

    // Next state and start pulses.
    always_comb begin
        state_d = state_q;
        start_d = '0;
        pop     = 1'b0;
        case (state_q)
            ST_BOOT: begin
                start_d[0] = 1'b1;
                state_d    = ST_RUNNING;
            end
            ST_RUNNING: begin
                if ((count_q != 5'd0) && disp_vld) begin
                    pop               = 1'b1;
                    start_d[disp_idx] = 1'b1;
                end
                // Two quiet cycles in a row so a halt racing a last spawn is not mistaken for completion.
                if (quiet && quiet_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (pending != '0) state_d = ST_RUNNING;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_BOOT;
            seen_q       <= bus.TRIGGER_SPAWN;
            ack_q        <= '0;
            start_q      <= '0;
            start_addr_q <= '0;
            count_q      <= 5'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rr_ptr_q     <= '0;
            quiet_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            quiet_q <= (state_q == ST_RUNNING) && quiet;

            if (state_q == ST_BOOT) start_addr_q[7:0] <= BOOT_ADDR;
            if (pop) begin
                start_addr_q[int'(disp_idx)*8 +: 8] <= mem[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end

            if (push) begin
                wr_ptr_q         <= wr_ptr_q + AW'(1);
                seen_q[pick_idx] <= bus.TRIGGER_SPAWN[pick_idx];
                ack_q[pick_idx]  <= ~ack_q[pick_idx];
                rr_ptr_q         <= (pick_idx == PW'(N_PROC - 1)) ? '0 : pick_idx + PW'(1);
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 5'd1;
                2'b01:   count_q <= count_q - 5'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= bus.SPAWN_ADDR[int'(pick_idx)*8 +: 8];
    end

    assign bus.DISP_ACK   = ack_q;
    assign bus.START      = start_q;
    assign bus.START_ADDR = start_addr_q;
    assign bus.ALL_IDLE   = (state_q == ST_DONE);
    assign bus.FIFO_COUNT = count_q;

`ifdef DISPATCH_STATS_EN
    logic [15:0] spawn_total_q;
    logic [15:0] start_total_q;
    logic [4:0]  fifo_hwm_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            spawn_total_q <= '0;
            start_total_q <= '0;
            fifo_hwm_q    <= '0;
        end else begin
            if (push && (spawn_total_q != 16'hFFFF))          spawn_total_q <= spawn_total_q + 16'd1;
            if ((start_d != '0) && (start_total_q != 16'hFFFF)) start_total_q <= start_total_q + 16'd1;
            if (count_q > fifo_hwm_q)                          fifo_hwm_q    <= count_q;
        end
    end

    assign bus.SPAWN_TOTAL = spawn_total_q;
    assign bus.START_TOTAL = start_total_q;
    assign bus.FIFO_HWM    = fifo_hwm_q;
`endif

endmodule

// File: tb/tb_spawn_dispatcher.sv
// Directed bench for spawn_dispatcher: boot, single spawn, round-robin, completion, mid-run reset, full-FIFO stall.
// dut uses FIFO_DEPTH=8 with a simple processor model (RUN follows START by one edge); dut2 uses FIFO_DEPTH=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_spawn_dispatcher;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   auto_run;

    always #5 clock = ~clock;

    spawn_dispatcher_if #(.N_PROC(4)) bus ();
    spawn_dispatcher_if #(.N_PROC(4)) bus2 ();

    spawn_dispatcher #(.N_PROC(4), .FIFO_DEPTH(8), .BOOT_ADDR(8'h00)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    spawn_dispatcher #(.N_PROC(4), .FIFO_DEPTH(2), .BOOT_ADDR(8'h00)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.master)
    );

    // One clock; processors of dut start running on the edge that sees their START pulse.
    task automatic step();
        logic [3:0] st;
        st = bus.START;
        @(posedge clock);
        #1;
        if (auto_run) bus.RUN = bus.RUN | st;
    endtask

    // Reset both DUTs, release, let P0 boot and start running.
    task automatic boot(input logic [3:0] run2);
        reset    = 1'b1;
        bus.RUN  = 4'b0000;
        bus2.RUN = run2;
        step();
        step();
        reset = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        bus.TRIGGER_SPAWN = 4'b0010;  // stale level held during reset
        step();
        step();
        checks++; if (bus.START !== 4'b0000) begin errors++; $display("FAIL rst_start got=%b exp=%b", bus.START, 4'b0000); end
        checks++; if (bus.DISP_ACK !== 4'b0000) begin errors++; $display("FAIL rst_ack got=%b exp=%b", bus.DISP_ACK, 4'b0000); end
        checks++; if (bus.FIFO_COUNT !== 5'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", bus.FIFO_COUNT); end
        checks++; if (bus.ALL_IDLE !== 1'b0) begin errors++; $display("FAIL rst_idle got=%b exp=0", bus.ALL_IDLE); end
        checks++; if (bus.START_ADDR !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=%h", bus.START_ADDR, 32'h0); end
    endtask

    task automatic test_boot();
        reset = 1'b0;
        step();
        checks++; if (bus.START !== 4'b0001) begin errors++; $display("FAIL boot_start got=%b exp=%b", bus.START, 4'b0001); end
        checks++; if (bus.START_ADDR[7:0] !== 8'h00) begin errors++; $display("FAIL boot_addr got=%h exp=00", bus.START_ADDR[7:0]); end
        checks++; if (bus.DISP_ACK !== 4'b0000) begin errors++; $display("FAIL boot_stale_ack got=%b exp=%b", bus.DISP_ACK, 4'b0000); end
        step();
        checks++; if (bus.START !== 4'b0000) begin errors++; $display("FAIL boot_one_pulse got=%b exp=%b", bus.START, 4'b0000); end
        checks++; if (bus.DISP_ACK !== 4'b0000) begin errors++; $display("FAIL boot_stale_ack2 got=%b exp=%b", bus.DISP_ACK, 4'b0000); end
        checks++; if (bus.ALL_IDLE !== 1'b0) begin errors++; $display("FAIL boot_idle got=%b exp=0", bus.ALL_IDLE); end
    endtask

    task automatic test_single_spawn();
        bus.TRIGGER_SPAWN = bus.TRIGGER_SPAWN ^ 4'b0001;
        bus.SPAWN_ADDR    = {8'h00, 8'h00, 8'h00, 8'h20};
        step();
        checks++; if (bus.DISP_ACK !== 4'b0001) begin errors++; $display("FAIL single_ack got=%b exp=%b", bus.DISP_ACK, 4'b0001); end
        checks++; if (bus.FIFO_COUNT !== 5'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", bus.FIFO_COUNT); end
        checks++; if (bus.START !== 4'b0000) begin errors++; $display("FAIL single_no_bypass got=%b exp=%b", bus.START, 4'b0000); end
        step();
        checks++; if (bus.START !== 4'b0010) begin errors++; $display("FAIL single_start got=%b exp=%b", bus.START, 4'b0010); end
        checks++; if (bus.START_ADDR[15:8] !== 8'h20) begin errors++; $display("FAIL single_addr got=%h exp=20", bus.START_ADDR[15:8]); end
        checks++; if (bus.FIFO_COUNT !== 5'd0) begin errors++; $display("FAIL single_pop got=%0d exp=0", bus.FIFO_COUNT); end
        step();
        checks++; if (bus.START !== 4'b0000) begin errors++; $display("FAIL single_pulse got=%b exp=%b", bus.START, 4'b0000); end
        checks++; if (bus.START_ADDR[15:8] !== 8'h20) begin errors++; $display("FAIL single_hold got=%h exp=20", bus.START_ADDR[15:8]); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_ack   [4];
        logic [3:0]  exp_start [4];
        logic [7:0]  exp_addr  [4];
        exp_ack   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        exp_start = '{4'b0000, 4'b0010, 4'b0100, 4'b1000};
        exp_addr  = '{8'h00, 8'h10, 8'h11, 8'h12};
        boot(4'b0000);
        bus.TRIGGER_SPAWN = bus.TRIGGER_SPAWN ^ 4'b1111;
        bus.SPAWN_ADDR    = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int e = 0; e < 4; e++) begin
            step();
            checks++; if (bus.DISP_ACK !== exp_ack[e]) begin errors++; $display("FAIL rr_ack[%0d] got=%b exp=%b", e, bus.DISP_ACK, exp_ack[e]); end
            checks++; if (bus.START !== exp_start[e]) begin errors++; $display("FAIL rr_start[%0d] got=%b exp=%b", e, bus.START, exp_start[e]); end
            checks++; if (bus.FIFO_COUNT !== 5'd1) begin errors++; $display("FAIL rr_count[%0d] got=%0d exp=1", e, bus.FIFO_COUNT); end
            if (e > 0) begin
                checks++; if (bus.START_ADDR[e*8 +: 8] !== exp_addr[e]) begin errors++; $display("FAIL rr_addr[%0d] got=%h exp=%h", e, bus.START_ADDR[e*8 +: 8], exp_addr[e]); end
            end
        end
        step();
        checks++; if (bus.START !== 4'b0000) begin errors++; $display("FAIL rr_all_busy got=%b exp=%b", bus.START, 4'b0000); end
        checks++; if (bus.FIFO_COUNT !== 5'd1) begin errors++; $display("FAIL rr_queued got=%0d exp=1", bus.FIFO_COUNT); end
        bus.RUN[1] = 1'b0;
        step();
        checks++; if (bus.START !== 4'b0010) begin errors++; $display("FAIL rr_last_start got=%b exp=%b", bus.START, 4'b0010); end
        checks++; if (bus.START_ADDR[15:8] !== 8'h13) begin errors++; $display("FAIL rr_last_addr got=%h exp=13", bus.START_ADDR[15:8]); end
        checks++; if (bus.FIFO_COUNT !== 5'd0) begin errors++; $display("FAIL rr_drained got=%0d exp=0", bus.FIFO_COUNT); end
    endtask

    task automatic test_completion();
        step();
        checks++; if (bus.START !== 4'b0000) begin errors++; $display("FAIL done_prestart got=%b exp=%b", bus.START, 4'b0000); end
        bus.RUN = 4'b0000;
        step();
        checks++; if (bus.ALL_IDLE !== 1'b0) begin errors++; $display("FAIL done_early got=%b exp=0", bus.ALL_IDLE); end
        step();
        checks++; if (bus.ALL_IDLE !== 1'b1) begin errors++; $display("FAIL done_set got=%b exp=1", bus.ALL_IDLE); end
        step();
        checks++; if (bus.ALL_IDLE !== 1'b1) begin errors++; $display("FAIL done_hold got=%b exp=1", bus.ALL_IDLE); end
        bus.TRIGGER_SPAWN = bus.TRIGGER_SPAWN ^ 4'b0100;
        bus.SPAWN_ADDR    = {8'h00, 8'h40, 8'h00, 8'h00};
        step();
        checks++; if (bus.ALL_IDLE !== 1'b0) begin errors++; $display("FAIL done_clear got=%b exp=0", bus.ALL_IDLE); end
        checks++; if (bus.DISP_ACK !== 4'b1011) begin errors++; $display("FAIL done_ack got=%b exp=%b", bus.DISP_ACK, 4'b1011); end
        checks++; if (bus.FIFO_COUNT !== 5'd1) begin errors++; $display("FAIL done_count got=%0d exp=1", bus.FIFO_COUNT); end
        step();
        checks++; if (bus.START !== 4'b0001) begin errors++; $display("FAIL done_restart got=%b exp=%b", bus.START, 4'b0001); end
        checks++; if (bus.START_ADDR[7:0] !== 8'h40) begin errors++; $display("FAIL done_restart_addr got=%h exp=40", bus.START_ADDR[7:0]); end
    endtask

    task automatic test_reset_mid();
        bus.RUN           = 4'b1111;
        bus.TRIGGER_SPAWN = bus.TRIGGER_SPAWN ^ 4'b0111;
        bus.SPAWN_ADDR    = {8'h00, 8'h52, 8'h51, 8'h50};
        step();
        step();
        step();
        checks++; if (bus.FIFO_COUNT !== 5'd3) begin errors++; $display("FAIL mid_fill got=%0d exp=3", bus.FIFO_COUNT); end
        checks++; if (bus.DISP_ACK !== 4'b1100) begin errors++; $display("FAIL mid_fill_ack got=%b exp=%b", bus.DISP_ACK, 4'b1100); end
        bus.TRIGGER_SPAWN = bus.TRIGGER_SPAWN ^ 4'b1000;  // held through reset
        reset = 1'b1;
        step();
        checks++; if (bus.FIFO_COUNT !== 5'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", bus.FIFO_COUNT); end
        checks++; if (bus.DISP_ACK !== 4'b0000) begin errors++; $display("FAIL mid_ack got=%b exp=%b", bus.DISP_ACK, 4'b0000); end
        checks++; if (bus.START !== 4'b0000) begin errors++; $display("FAIL mid_start got=%b exp=%b", bus.START, 4'b0000); end
        step();
        reset = 1'b0;
        checks++; if (bus.START !== 4'b0000) begin errors++; $display("FAIL mid_start2 got=%b exp=%b", bus.START, 4'b0000); end
        step();
        checks++; if (bus.START !== 4'b0001) begin errors++; $display("FAIL mid_boot got=%b exp=%b", bus.START, 4'b0001); end
        checks++; if (bus.DISP_ACK !== 4'b0000) begin errors++; $display("FAIL mid_stale_ack got=%b exp=%b", bus.DISP_ACK, 4'b0000); end
        step();
        checks++; if (bus.DISP_ACK !== 4'b0000) begin errors++; $display("FAIL mid_stale_ack2 got=%b exp=%b", bus.DISP_ACK, 4'b0000); end
        checks++; if (bus.FIFO_COUNT !== 5'd0) begin errors++; $display("FAIL mid_count2 got=%0d exp=0", bus.FIFO_COUNT); end
    endtask

    task automatic test_backpressure();
        boot(4'b1111);
        bus2.TRIGGER_SPAWN = bus2.TRIGGER_SPAWN ^ 4'b0111;
        bus2.SPAWN_ADDR    = {8'h00, 8'h32, 8'h31, 8'h30};
        step();
        checks++; if (bus2.DISP_ACK !== 4'b0001) begin errors++; $display("FAIL bp_ack1 got=%b exp=%b", bus2.DISP_ACK, 4'b0001); end
        step();
        checks++; if (bus2.DISP_ACK !== 4'b0011) begin errors++; $display("FAIL bp_ack2 got=%b exp=%b", bus2.DISP_ACK, 4'b0011); end
        checks++; if (bus2.FIFO_COUNT !== 5'd2) begin errors++; $display("FAIL bp_full got=%0d exp=2", bus2.FIFO_COUNT); end
        step();
        step();
        checks++; if (bus2.DISP_ACK !== 4'b0011) begin errors++; $display("FAIL bp_stall got=%b exp=%b", bus2.DISP_ACK, 4'b0011); end
        checks++; if (bus2.FIFO_COUNT !== 5'd2) begin errors++; $display("FAIL bp_stall_count got=%0d exp=2", bus2.FIFO_COUNT); end
        bus2.RUN = 4'b1101;
        step();
        checks++; if (bus2.START !== 4'b0010) begin errors++; $display("FAIL bp_pop got=%b exp=%b", bus2.START, 4'b0010); end
        checks++; if (bus2.START_ADDR[15:8] !== 8'h30) begin errors++; $display("FAIL bp_pop_addr got=%h exp=30", bus2.START_ADDR[15:8]); end
        checks++; if (bus2.DISP_ACK !== 4'b0011) begin errors++; $display("FAIL bp_no_push_on_pop got=%b exp=%b", bus2.DISP_ACK, 4'b0011); end
        checks++; if (bus2.FIFO_COUNT !== 5'd1) begin errors++; $display("FAIL bp_pop_count got=%0d exp=1", bus2.FIFO_COUNT); end
        bus2.RUN = 4'b1111;
        step();
        checks++; if (bus2.DISP_ACK !== 4'b0111) begin errors++; $display("FAIL bp_ack3 got=%b exp=%b", bus2.DISP_ACK, 4'b0111); end
        checks++; if (bus2.FIFO_COUNT !== 5'd2) begin errors++; $display("FAIL bp_refill got=%0d exp=2", bus2.FIFO_COUNT); end
        checks++; if (bus2.START !== 4'b0000) begin errors++; $display("FAIL bp_no_start got=%b exp=%b", bus2.START, 4'b0000); end
    endtask

    initial begin
        reset              = 1'b1;
        auto_run           = 1'b1;
        bus.RUN            = 4'b0000;
        bus.TRIGGER_SPAWN  = 4'b0000;
        bus.SPAWN_ADDR     = 32'h0;
        bus2.RUN           = 4'b0000;
        bus2.TRIGGER_SPAWN = 4'b0000;
        bus2.SPAWN_ADDR    = 32'h0;

        test_reset();
        test_boot();
        test_single_spawn();
        test_round_robin();
        test_completion();
        test_reset_mid();
        test_backpressure();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
